// File: rtl/pack_pkg.sv
// Shared definitions for the two-source byte packer.
//
// Contents:
//   BYTES_PER_WORD, BYTE_W, WORD_W, SLOT_W : word geometry
//   state_t                                : arbiter FSM states
//   src_t                                  : source index (0 or 1)
//   place_byte()                           : writes one byte into a word slot
//                                            (slot 0 = most significant byte)
package pack_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned SLOT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    typedef logic [0:0] src_t;

    function automatic logic [WORD_W-1:0] place_byte(
        input logic [WORD_W-1:0] word,
        input logic [BYTE_W-1:0] data,
        input logic [SLOT_W-1:0] slot
    );
        logic [WORD_W-1:0] res;
        res = word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (slot == SLOT_W'(i)) begin
                res[WORD_W-1-BYTE_W*i -: BYTE_W] = data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects bytes into a 32-bit word and presents finished words on a
// valid/ready output register.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   byte_data     : byte to store at slot cnt when strobe is high
//   strobe        : accept byte_data this cycle
//   flush         : emit the partial word now (unused low bytes are zero)
//   src           : source tag captured with the word
//   out_ready     : consumer accepts the held word
//   cnt           : number of bytes currently stored (0..3)
//   out_free      : output register can take a new word this cycle
//   out_data/out_src/out_bytes/out_valid : word output
//
// The caller must only strobe the 4th byte while out_free is high and must
// only flush with cnt > 0, out_free high and no strobe.
module byte_assembler
    import pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              strobe,
    input  logic              flush,
    input  src_t              src,
    input  logic              out_ready,
    output logic [SLOT_W-1:0] cnt,
    output logic              out_free,
    output logic [WORD_W-1:0] out_data,
    output src_t              out_src,
    output logic [2:0]        out_bytes,
    output logic              out_valid
);

    logic [WORD_W-1:0] slots_q;
    logic [SLOT_W-1:0] cnt_q;
    logic [WORD_W-1:0] word_next;
    logic              last_byte;
    logic              load;

    always_comb begin
        word_next = place_byte(slots_q, byte_data, cnt_q);
        last_byte = strobe && (cnt_q == SLOT_W'(BYTES_PER_WORD - 1));
        load      = last_byte || flush;
        out_free  = !out_valid || out_ready;
        cnt       = cnt_q;
    end

    // Slots are cleared whenever a word leaves, so a flushed partial word
    // already carries zeros in its unused low bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            slots_q <= '0;
            cnt_q   <= '0;
        end else if (strobe) begin
            slots_q <= word_next;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // A new word loading in the same cycle as out_ready replaces the old one
    // and keeps out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_src   <= '0;
            out_bytes <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= last_byte ? word_next : slots_q;
            out_src   <= src;
            out_bytes <= last_byte ? 3'(BYTES_PER_WORD) : {1'b0, cnt_q};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_pack_arbiter.sv
// Shares one 4-byte word assembler between two 8-bit byte streams. A source
// is granted for a whole word (round-robin), so words never mix sources.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in0_data/in0_valid/in0_ready   : byte stream from source 0
//   in1_data/in1_valid/in1_ready   : byte stream from source 1
//   out_data   : packed word, first accepted byte in [31:24]
//   out_src    : source of out_data
//   out_bytes  : valid bytes in out_data (1..4)
//   out_valid/out_ready : word handshake
//   busy       : high while a word is being collected
//
// Configuration macro PACK_TIMEOUT_EN: when defined, a partial word that sees
// TIMEOUT_CYCLES cycles without a new byte is flushed with out_bytes = count.
// When undefined there is no timeout logic and every word carries 4 bytes.
module byte_pack_arbiter
    import pack_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [BYTE_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic [WORD_W-1:0] out_data,
    output src_t              out_src,
    output logic [2:0]        out_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t state_q, state_d;
    src_t   grant_q, grant_d;
    src_t   last_grant_q, last_grant_d;

    logic [SLOT_W-1:0] cnt;
    logic              out_free;
    logic              accept;
    logic              flush;
    logic [BYTE_W-1:0] sel_data;

    // Ready/accept path for the granted source only.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        accept    = 1'b0;
        sel_data  = grant_q[0] ? in1_data : in0_data;
        if (state_q == COLLECT) begin
            // Only the word-completing byte needs room in the output register.
            if (grant_q[0]) begin
                in1_ready = (cnt != SLOT_W'(BYTES_PER_WORD - 1)) || out_free;
                accept    = in1_valid && in1_ready;
            end else begin
                in0_ready = (cnt != SLOT_W'(BYTES_PER_WORD - 1)) || out_free;
                accept    = in0_valid && in0_ready;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (in0_valid || in1_valid) begin
                    if (in0_valid && in1_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = in1_valid ? src_t'(1'b1) : src_t'(1'b0);
                    end
                    last_grant_d = grant_d;
                    state_d      = COLLECT;
                end
            end
            COLLECT: begin
                if ((accept && (cnt == SLOT_W'(BYTES_PER_WORD - 1))) || flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= src_t'(1'b1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy = (state_q == COLLECT);

`ifdef PACK_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_q;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q >= CNT_W'(TIMEOUT_CYCLES));

    // Counts idle cycles of a partial word; saturates so a stalled output
    // register only delays the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if ((state_q != COLLECT) || (cnt == '0) || accept) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign flush = (state_q == COLLECT) && (cnt != '0) && !accept && tmo_hit && out_free;
`else
    logic [CNT_W-1:0] unused_tmo_cfg;
    assign unused_tmo_cfg = CNT_W'(TIMEOUT_CYCLES);
    assign flush = 1'b0;
`endif

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .byte_data (sel_data),
        .strobe    (accept),
        .flush     (flush),
        .src       (grant_q),
        .out_ready (out_ready),
        .cnt       (cnt),
        .out_free  (out_free),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_bytes (out_bytes),
        .out_valid (out_valid)
    );

endmodule
